// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared state encoding and time-compare helper for the alarm ringing controller.
package alarm_ring_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    // True when the running time sits exactly on the alarm minute, second 00.
    function automatic logic time_match(
        input logic [2:0] min_tens,
        input logic [3:0] min_ones,
        input logic [2:0] sec_tens,
        input logic [3:0] sec_ones,
        input logic [2:0] alm_tens,
        input logic [3:0] alm_ones
    );
        return (min_tens == alm_tens) && (min_ones == alm_ones) &&
               (sec_tens == 3'd0) && (sec_ones == 4'd0);
    endfunction

endpackage

// File: rtl/alarm_ring_ctrl_rise_detect.sv
// One-cycle pulse on a rising edge of a same-domain level; reset value selectable.
module rise_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) d_q <= RST_VAL;
        else        d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing controller: match detect, blinking LED, limited snooze, timeout, cancel.
module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned MAX_SNOOZES      = 3,
    parameter int unsigned BLINK_HALF_CYC   = 25_000_000
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       sec_signal,
    input  logic [2:0] minutes_tens,
    input  logic [3:0] minutes_ones,
    input  logic [2:0] seconds_tens,
    input  logic [3:0] seconds_ones,
    input  logic [2:0] alarm_min_tens,
    input  logic [3:0] alarm_min_ones,
    input  logic       alarm_en,
    input  logic       load,
    input  logic       snooze_btn,
    output logic       alarm_led,
    output logic       ringing,
    output logic       snoozing
);

    localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SW = $clog2(MAX_SNOOZES + 1);
    localparam int TW = $clog2(SNOOZE_SEC + 1);
    localparam int BW = $clog2(BLINK_HALF_CYC + 1);

    localparam logic [RW-1:0] RING_LAST  = RW'(RING_TIMEOUT_SEC - 1);
    localparam logic [SW-1:0] SNZ_MAX    = SW'(MAX_SNOOZES);
    localparam logic [TW-1:0] SNZ_INIT   = TW'(SNOOZE_SEC);
    localparam logic [TW-1:0] SNZ_ONE    = TW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);

    logic tick;
    logic snz;
    logic match;

    state_t        state_q;
    logic [RW-1:0] ring_cnt_q;
    logic [SW-1:0] snooze_cnt_q;
    logic [TW-1:0] snz_timer_q;
    logic [BW-1:0] blink_q;
    logic          led_q;
    logic          ringing_q;
    logic          snoozing_q;

    // Seconds edge register resets high so a high sec_signal at reset release is not a tick.
    rise_detect #(.RST_VAL(1'b1)) u_sec_edge (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .d     (sec_signal),
        .pulse (tick)
    );

    rise_detect #(.RST_VAL(1'b0)) u_snz_edge (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .d     (snooze_btn),
        .pulse (snz)
    );

    assign match = tick & time_match(minutes_tens, minutes_ones, seconds_tens, seconds_ones,
                                     alarm_min_tens, alarm_min_ones);

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            snz_timer_q  <= '0;
            blink_q      <= '0;
            led_q        <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match && alarm_en && !load) begin
                        state_q      <= ST_RINGING;
                        ring_cnt_q   <= '0;
                        snooze_cnt_q <= '0;
                        blink_q      <= '0;
                        led_q        <= 1'b1;
                        ringing_q    <= 1'b1;
                        snoozing_q   <= 1'b0;
                    end
                end
                ST_RINGING: begin
                    if (!alarm_en) begin
                        state_q    <= ST_IDLE;
                        led_q      <= 1'b0;
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b0;
                    end else if (snz && (snooze_cnt_q < SNZ_MAX)) begin
                        state_q      <= ST_SNOOZE;
                        snooze_cnt_q <= snooze_cnt_q + 1'b1;
                        snz_timer_q  <= SNZ_INIT;
                        led_q        <= 1'b0;
                        ringing_q    <= 1'b0;
                        snoozing_q   <= 1'b1;
                    end else if (tick && (ring_cnt_q == RING_LAST)) begin
                        state_q    <= ST_IDLE;
                        led_q      <= 1'b0;
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b0;
                    end else begin
                        if (tick) ring_cnt_q <= ring_cnt_q + 1'b1;
                        if (blink_q == BLINK_LAST) begin
                            blink_q <= '0;
                            led_q   <= ~led_q;
                        end else begin
                            blink_q <= blink_q + 1'b1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (!alarm_en) begin
                        state_q    <= ST_IDLE;
                        led_q      <= 1'b0;
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b0;
                    end else if (tick && (snz_timer_q == SNZ_ONE)) begin
                        state_q    <= ST_RINGING;
                        ring_cnt_q <= '0;
                        blink_q    <= '0;
                        led_q      <= 1'b1;
                        ringing_q  <= 1'b1;
                        snoozing_q <= 1'b0;
                    end else if (tick) begin
                        snz_timer_q <= snz_timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    led_q      <= 1'b0;
                    ringing_q  <= 1'b0;
                    snoozing_q <= 1'b0;
                end
            endcase
        end
    end

    assign alarm_led = led_q;
    assign ringing   = ringing_q;
    assign snoozing  = snoozing_q;

endmodule
